// File: rtl/byte_decode_stream_ctrl.sv
// Serial ByteDecode_ell sequencer: repacks a valid/ready byte stream into ELL-bit
// coefficients, optionally reduced mod Q, emitted one per beat with an index.
module byte_decode_stream_ctrl #(
  parameter int ELL        = 12,
  parameter int NUM_COEFFS = 256,
  parameter int Q          = 3329,
  parameter int REDUCE     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [ELL-1:0]                coeff_out,
  output logic [$clog2(NUM_COEFFS)-1:0] coeff_idx,
  output logic                          coeff_valid,
  input  logic                          coeff_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IDX_W       = $clog2(NUM_COEFFS);
  localparam int unsigned TOTAL_BYTES = NUM_COEFFS * ELL / 8;
  localparam int unsigned BL_W        = $clog2(TOTAL_BYTES + 1);
  localparam int unsigned BUF_W       = ELL + 7;
  localparam int unsigned BC_W        = $clog2(ELL + 8);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [BUF_W-1:0]  bitbuf;
  logic [BC_W-1:0]   bitcnt;
  logic [BL_W-1:0]   bytes_left;
  logic [IDX_W-1:0]  emit_cnt;
  logic              accept, emit, last_taken;

  // A single conditional subtract suffices because a 12-bit value is below 2Q.
  function automatic logic [ELL-1:0] reduce(input logic [ELL-1:0] x);
    if (REDUCE != 0 && ELL == 12 && x >= ELL'(Q))
      return x - ELL'(Q);
    return x;
  endfunction

  always_comb begin
    accept     = byte_valid & byte_ready;
    emit       = (state == S_RUN) && (bitcnt >= BC_W'(ELL)) && (!coeff_valid || coeff_ready);
    last_taken = coeff_valid && coeff_ready && (coeff_idx == IDX_W'(NUM_COEFFS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN:   if (last_taken) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    byte_ready = (state == S_RUN) && (bitcnt < BC_W'(ELL)) && (bytes_left != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitbuf      <= '0;
      bitcnt      <= '0;
      bytes_left  <= '0;
      emit_cnt    <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
    end else if (abort) begin
      bitbuf      <= '0;
      bitcnt      <= '0;
      bytes_left  <= '0;
      emit_cnt    <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
    end else if (state == S_IDLE && start) begin
      bitbuf      <= '0;
      bitcnt      <= '0;
      bytes_left  <= BL_W'(TOTAL_BYTES);
      emit_cnt    <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
    end else if (state == S_RUN) begin
      // Accept needs bitcnt < ELL and emit needs bitcnt >= ELL, so only one branch can fire.
      if (emit) begin
        coeff_out   <= reduce(bitbuf[ELL-1:0]);
        bitbuf      <= bitbuf >> ELL;
        bitcnt      <= bitcnt - BC_W'(ELL);
        coeff_idx   <= emit_cnt;
        emit_cnt    <= emit_cnt + 1'b1;
        coeff_valid <= 1'b1;
      end else begin
        if (accept) begin
          bitbuf[bitcnt +: 8] <= byte_in;
          bitcnt              <= bitcnt + BC_W'(8);
          bytes_left          <= bytes_left - 1'b1;
        end
        if (coeff_ready)
          coeff_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_decode_stream_ctrl.sv
// Directed bench: ELL=12/REDUCE=1 instance against a bit-level golden model,
// plus an ELL=1, NUM_COEFFS=8 instance for the single-bit corner.
module tb_byte_decode_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: ELL=12, NUM_COEFFS=256, REDUCE=1
  logic        a_start = 0, a_abort = 0, a_byte_valid = 0, a_coeff_ready = 0;
  logic [7:0]  a_byte_in = '0;
  logic        a_byte_ready, a_coeff_valid, a_busy, a_done;
  logic [11:0] a_coeff_out;
  logic [7:0]  a_coeff_idx;

  byte_decode_stream_ctrl #(.ELL(12), .NUM_COEFFS(256), .Q(3329), .REDUCE(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .byte_in(a_byte_in), .byte_valid(a_byte_valid), .byte_ready(a_byte_ready),
    .coeff_out(a_coeff_out), .coeff_idx(a_coeff_idx), .coeff_valid(a_coeff_valid),
    .coeff_ready(a_coeff_ready), .busy(a_busy), .done(a_done)
  );

  // Instance B: ELL=1, NUM_COEFFS=8
  logic        b_start = 0, b_abort = 0, b_byte_valid = 0, b_coeff_ready = 0;
  logic [7:0]  b_byte_in = '0;
  logic        b_byte_ready, b_coeff_valid, b_busy, b_done;
  logic [0:0]  b_coeff_out;
  logic [2:0]  b_coeff_idx;

  byte_decode_stream_ctrl #(.ELL(1), .NUM_COEFFS(8), .Q(3329), .REDUCE(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .byte_in(b_byte_in), .byte_valid(b_byte_valid), .byte_ready(b_byte_ready),
    .coeff_out(b_coeff_out), .coeff_idx(b_coeff_idx), .coeff_valid(b_coeff_valid),
    .coeff_ready(b_coeff_ready), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [7:0]  mem [0:383];
  logic [11:0] got_out [0:255];
  int bptr, cidx, done_cnt, done_cyc, last_cyc;

  // Golden model: bit j of coefficient i is stream bit i*12+j, then mod-Q fold.
  function automatic logic [11:0] exp_coeff(input int i);
    int v = 0;
    for (int j = 0; j < 12; j++) begin
      int s = i * 12 + j;
      v |= ((int'(mem[s / 8]) >> (s % 8)) & 1) << j;
    end
    if (v >= 3329) v -= 3329;
    return 12'(v);
  endfunction

  function automatic logic [31:0] a_outs();
    return 32'({a_byte_ready, a_coeff_valid, a_busy, a_done, a_coeff_idx, a_coeff_out});
  endfunction

  task automatic a_go();
    @(negedge clk);
    a_start = 1; a_byte_valid = 0; a_coeff_ready = 0;
    @(negedge clk);
    a_start = 0;
    check("a_busy_after_start", 32'(a_busy), 1);
  endtask

  task automatic a_run(input int max_bytes, input int stop_idx, input int stall_cycles,
                       input int abort_idx, input bit poke_start);
    int  stall_left = 0;
    bit  stalled_once = 0, finished = 0;
    int  tail = 0;
    logic [11:0] hold_out = '0;
    logic [7:0]  hold_idx = '0;
    bptr = 0; cidx = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge clk);
      a_start = 0; a_abort = 0;
      if (a_done) begin done_cnt++; done_cyc = cyc; end
      if (cidx >= stop_idx) begin
        a_byte_valid = 0; a_coeff_ready = 1;
        tail++;
        if (tail > 3) finished = 1;
      end else if (abort_idx >= 0 && a_coeff_valid && 32'(a_coeff_idx) == abort_idx) begin
        a_abort = 1; a_byte_valid = 1; a_coeff_ready = 1;
        @(negedge clk);
        a_abort = 0; a_byte_valid = 0; a_coeff_ready = 0;
        check("abort_cleared_outputs", a_outs(), 0);
        @(negedge clk);
        check("abort_no_done", 32'(a_done), 0);
        finished = 1;
      end else begin
        if (!stalled_once && stall_cycles > 0 && a_coeff_valid) begin
          stalled_once = 1; stall_left = stall_cycles - 1;
          hold_out = a_coeff_out; hold_idx = a_coeff_idx;
          a_coeff_ready = 0;
        end else if (stall_left > 0) begin
          check("stall_out_stable", 32'(a_coeff_out), 32'(hold_out));
          check("stall_idx_stable", 32'(a_coeff_idx), 32'(hold_idx));
          stall_left--;
          a_coeff_ready = 0;
          if (stall_left == 0) check("stall_byte_ready_low", 32'(a_byte_ready), 0);
        end else begin
          a_coeff_ready = 1;
        end
        a_byte_valid = (bptr < max_bytes);
        a_byte_in    = (bptr < 384) ? mem[bptr] : 8'h00;
        if (a_byte_valid && a_byte_ready) bptr++;
        if (a_coeff_valid && a_coeff_ready) begin
          check($sformatf("idx[%0d]", cidx), 32'(a_coeff_idx), 32'(cidx));
          check($sformatf("coeff[%0d]", cidx), 32'(a_coeff_out), 32'(exp_coeff(cidx)));
          got_out[cidx] = a_coeff_out;
          cidx++;
          last_cyc = cyc;
        end
        if (poke_start && cidx == 20) a_start = 1;
      end
    end
    check("a_run_finished", 32'(finished), 1);
  endtask

  task automatic a_check_end(input string tag);
    check({tag, "_done_once"}, 32'(done_cnt), 1);
    check({tag, "_done_timing"}, 32'(done_cyc - last_cyc), 1);
    check({tag, "_bytes_taken"}, 32'(bptr), 384);
    check({tag, "_byte_ready_low"}, 32'(a_byte_ready), 0);
    check({tag, "_idle"}, 32'(a_busy), 0);
  endtask

  initial begin
    int  bn, bfed, bdone;
    logic [7:0] pat;

    repeat (2) @(negedge clk);
    check("reset_a", a_outs(), 0);
    check("reset_b", 32'({b_byte_ready, b_coeff_valid, b_busy, b_done, b_coeff_idx, b_coeff_out}), 0);
    rst = 0;

    // Short stream: 01 23 45 -> 0x301, 0x452
    mem[0] = 8'h01; mem[1] = 8'h23; mem[2] = 8'h45;
    a_go();
    a_run(3, 2, 0, -1, 0);
    check("t1_coeff0", 32'(got_out[0]), 32'h301);
    check("t1_coeff1", 32'(got_out[1]), 32'h452);
    @(negedge clk); a_abort = 1;
    @(negedge clk); a_abort = 0;
    check("t1_abort_idle", a_outs(), 0);

    // All-ones stream: every coefficient is 4095 mod 3329 = 766
    for (int k = 0; k < 384; k++) mem[k] = 8'hFF;
    a_go();
    a_run(384, 256, 0, -1, 0);
    a_check_end("ones");
    check("ones_first", 32'(got_out[0]), 766);
    check("ones_last", 32'(got_out[255]), 766);

    // Sink stalls 10 cycles after the first emit
    for (int k = 0; k < 384; k++) mem[k] = 8'(k * 37 + 11);
    a_go();
    a_run(384, 256, 10, -1, 0);
    a_check_end("stall");

    // Reset mid-stream after 100 bytes, then a fresh stream
    a_go();
    a_run(100, 66, 0, -1, 0);
    check("pre_reset_bytes", 32'(bptr), 100);
    @(negedge clk);
    rst = 1;
    #1 check("mid_reset_outputs", a_outs(), 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 384; k++) mem[k] = 8'(k * 91 + 5);
    a_go();
    a_run(384, 256, 0, -1, 0);
    a_check_end("after_reset");

    // start while busy ignored, abort at idx 40, then a clean decode
    for (int k = 0; k < 384; k++) mem[k] = 8'(k) ^ 8'h5A;
    a_go();
    a_run(384, 256, 0, 40, 1);
    check("abort_at_idx", 32'(cidx), 40);
    a_go();
    a_run(384, 256, 0, -1, 0);
    a_check_end("after_abort");

    // ELL=1: byte 0xA5 -> 1,0,1,0,0,1,0,1
    pat = 8'hA5; bn = 0; bfed = 0; bdone = 0;
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (b_done) bdone++;
      b_byte_valid = (bfed == 0);
      b_byte_in    = pat;
      if (b_byte_valid && b_byte_ready) bfed++;
      b_coeff_ready = 1;
      if (b_coeff_valid) begin
        check($sformatf("b_idx[%0d]", bn), 32'(b_coeff_idx), 32'(bn));
        check($sformatf("b_bit[%0d]", bn), 32'(b_coeff_out), 32'(pat[bn[2:0]]));
        bn++;
      end
    end
    check("b_count", 32'(bn), 8);
    check("b_done_once", 32'(bdone), 1);
    check("b_byte_ready_low", 32'(b_byte_ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_decode_stream_ctrl.md
Name: byte_decode_stream_ctrl

Overview:
- Streaming sequencer for the ByteDecode_ell step of Kyber polynomial unpacking.
- Accepts a serial byte stream over a valid/ready handshake and repacks it into NUM_COEFFS coefficients of ELL bits each, emitted one per beat with an index.
- Optionally reduces mod Q when ELL=12.
- Sits between the ciphertext/key byte buffer and the polynomial RAM writer; replaces the full-width combinational decode for area-constrained builds.

Parameters:
- ELL, 12, coefficient width in bits, legal 1..12.
- NUM_COEFFS, 256, coefficients per polynomial; NUM_COEFFS*ELL must be divisible by 8.
- Q, 3329, modulus used by the reduction stage.
- REDUCE, 1, when 1 and ELL==12 each coefficient is reduced mod Q; otherwise the raw value is passed through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a decode when idle.
- abort  in  1  synchronous clear back to IDLE; takes priority over every other input.
- byte_in  in  8  input byte; bit 0 is the first bit in the stream.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  the block accepts byte_in this cycle.
- coeff_out  out  ELL  output coefficient.
- coeff_idx  out  $clog2(NUM_COEFFS)  index of coeff_out.
- coeff_valid  out  1  coeff_out and coeff_idx are valid.
- coeff_ready  in  1  the sink accepts the coefficient.
- busy  out  1  high in the RUN state.
- done  out  1  one-cycle pulse after the last coefficient is accepted.

Behaviour:
- Reset values: state=IDLE; byte_ready, coeff_valid, busy, done = 0; coeff_out, coeff_idx = 0; bit buffer, bitcnt and all counters = 0. Reset mid-operation discards all partial data.
- States:
  - IDLE: start -> RUN; counters are cleared on entry to RUN.
  - RUN: processes bytes and coefficients. Once the coefficient with index NUM_COEFFS-1 is accepted (coeff_valid & coeff_ready), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - abort in any state -> IDLE next cycle, clears as reset does; done is not pulsed.
  - start is ignored outside IDLE.
- Bit buffer: ELL+7 bits, plus bitcnt from 0 to ELL+7.
- byte_ready = RUN & (bitcnt < ELL) & (bytes_left != 0).
  - bytes_left starts at NUM_COEFFS*ELL/8 and decrements on each accept.
  - byte_ready is a combinational function of registered state only; it must not depend on byte_valid.
- Byte accept (byte_valid & byte_ready): buf[bitcnt +: 8] <= byte_in; bitcnt += 8.
- Emit condition: RUN & (bitcnt >= ELL) & (!coeff_valid | coeff_ready). On emit:
  - coeff_out <= reduce(buf[ELL-1:0]);
  - buf is shifted right by ELL; bitcnt -= ELL;
  - coeff_idx <= emit counter; emit counter increments; coeff_valid <= 1.
- The accept and emit conditions are mutually exclusive by construction (bitcnt < ELL versus bitcnt >= ELL).
- Output register holds: coeff_out and coeff_idx stay stable while coeff_valid & !coeff_ready. coeff_valid drops after acceptance when no new emit occurs in that cycle.
- Bit mapping: bit j of coefficient i = stream bit i*ELL+j (little-endian within and across bytes).
- reduce(x) = (x >= Q) ? x - Q : x when REDUCE & ELL==12; otherwise x. Since x < 4096 < 2Q, a single conditional subtract is sufficient.
- Latency: first coefficient valid 1 cycle after the accept of the byte that completes it.
- Throughput with an always-ready source and sink: ELL=8 gives one coefficient per 2 cycles; ELL=12 gives 2 coefficients per 5 cycles.
- After the final coefficient is emitted, bytes_left=0 and bitcnt=0. byte_ready stays low until the next start.

Test Plan:
- ELL=12, REDUCE=0, start, then bytes 0x01,0x23,0x45 -> coeff 0 = 0x301 (idx 0), coeff 1 = 0x452 (idx 1).
- ELL=12, REDUCE=1, all 384 bytes = 0xFF -> 256 coefficients each 766 (4095-3329); done pulses once, one cycle after idx 255 is accepted; byte_ready low after byte 384.
- ELL=1, NUM_COEFFS=8, byte 0xA5 -> coefficients 1,0,1,0,0,1,0,1 at idx 0..7; done pulses.
- ELL=12, coeff_ready held low for 10 cycles after the first emit -> coeff_out/coeff_idx stable; byte_ready low once bitcnt >= 12; no byte lost; full-sequence coefficient values match a golden model.
- Assert rst mid-stream (after 100 bytes), then start and feed a fresh 384-byte stream -> all outputs 0 during reset; output matches a golden model from idx 0; no stale bits.
- start pulsed while busy -> ignored, index sequence uninterrupted; abort at idx 40 -> IDLE next cycle, coeff_valid=0, no done pulse, next start decodes correctly from idx 0.
